// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage pipeline: post-reset clear, load-use
// stall, taken-branch flush, data-memory freeze with timeout, stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int RESET_FLUSH_CYCLES = 4,
  parameter int MEM_TIMEOUT        = 255,
  parameter int WAIT_CNT_W         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic        idUsesRt,
  input  logic [4:0]  exeRt,
  input  logic        exeMemRead,
  input  logic        branchTaken,
  input  logic        memBusy,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        idExeWrite,
  output logic        exeMemWrite,
  output logic        memWbWrite,
  output logic        ifIdFlush,
  output logic        idExeFlush,
  output logic        exeMemFlush,
  output logic        memWbFlush,
  output logic [15:0] stallCount,
  output logic        memTimeout,
  output logic [1:0]  ctrlState
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam int INIT_W = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
  localparam logic [INIT_W-1:0]     INIT_LAST  = INIT_W'(RESET_FLUSH_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

  state_e                state_q, state_d;
  logic [INIT_W-1:0]     initCnt_q, initCnt_d;
  logic [WAIT_CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [15:0]           stallCnt_q, stallCnt_d;
  logic                  memTimeout_q, memTimeout_d;
  logic                  loadUse;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A zero destination never creates a dependency, so r0 loads do not stall.
  assign loadUse = exeMemRead && (exeRt != 5'd0) &&
                   ((exeRt == idRs) || (idUsesRt && (exeRt == idRt)));

  always_comb begin
    state_d      = state_q;
    initCnt_d    = initCnt_q;
    waitCnt_d    = '0;
    stallCnt_d   = stallCnt_q;
    memTimeout_d = memTimeout_q;
    pcWrite      = 1'b0;
    ifIdWrite    = 1'b0;
    idExeWrite   = 1'b0;
    exeMemWrite  = 1'b0;
    memWbWrite   = 1'b0;
    ifIdFlush    = 1'b0;
    idExeFlush   = 1'b0;
    exeMemFlush  = 1'b0;
    memWbFlush   = 1'b0;

    case (state_q)
      INIT: begin
        {ifIdWrite, idExeWrite, exeMemWrite, memWbWrite} = 4'b1111;
        {ifIdFlush, idExeFlush, exeMemFlush, memWbFlush} = 4'b1111;
        initCnt_d = initCnt_q + 1'b1;
        if (initCnt_q == INIT_LAST) begin
          state_d   = RUN;
          initCnt_d = '0;
        end
      end
      RUN, MEM_WAIT: begin
        if (memBusy) begin
          // Full freeze; a pending branch is held by the frozen EXE/MEM register.
          waitCnt_d  = waitCnt_q + 1'b1;
          stallCnt_d = sat_inc(stallCnt_q);
          if (waitCnt_q == WAIT_LIMIT) begin
            state_d      = HALT;
            memTimeout_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          state_d = RUN;
          pcWrite = 1'b1;
          {ifIdWrite, idExeWrite, exeMemWrite, memWbWrite} = 4'b1111;
          if (branchTaken) begin
            {ifIdFlush, idExeFlush, exeMemFlush} = 3'b111;
          end else if (loadUse) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExeFlush = 1'b1;
            stallCnt_d = sat_inc(stallCnt_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT;
      initCnt_q    <= '0;
      waitCnt_q    <= '0;
      stallCnt_q   <= '0;
      memTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      initCnt_q    <= initCnt_d;
      waitCnt_q    <= waitCnt_d;
      stallCnt_q   <= stallCnt_d;
      memTimeout_q <= memTimeout_d;
    end
  end

  assign stallCount = stallCnt_q;
  assign memTimeout = memTimeout_q;
  assign ctrlState  = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: hand vectors on a short-timeout instance, random
// traffic on both instances against a rule-level model, then long freeze corners.
module tb_pipeline_hazard_ctrl;

  localparam int RFC = 4;

  typedef struct packed {
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idUsesRt;
    logic [4:0] exeRt;
    logic       exeMemRead;
    logic       branchTaken;
    logic       memBusy;
  } in_t;

  typedef struct {
    in_t         x;
    logic [8:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic        tmo;
  } row_t;

  typedef struct {
    int mode;
    int initCnt;
    int busyRun;
    int stalls;
    bit tmo;
  } mdl_t;

  // {pcWrite, ifId/idExe/exeMem/memWb writes, ifId/idExe/exeMem/memWb flushes}
  localparam logic [8:0] INITV = 9'b0_1111_1111;
  localparam logic [8:0] NORM  = 9'b1_1111_0000;
  localparam logic [8:0] FRZ   = 9'b0_0000_0000;
  localparam logic [8:0] BR    = 9'b1_1111_1110;
  localparam logic [8:0] LU    = 9'b0_0111_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  idRs, idRt, exeRt;
  logic        idUsesRt, exeMemRead, branchTaken, memBusy;
  logic [8:0]  ctlA, ctlB;
  logic [1:0]  stA, stB;
  logic [15:0] scA, scB;
  logic        tmoA, tmoB;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.RESET_FLUSH_CYCLES(RFC), .MEM_TIMEOUT(4), .WAIT_CNT_W(16)) dutA (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exeRt(exeRt), .exeMemRead(exeMemRead), .branchTaken(branchTaken), .memBusy(memBusy),
    .pcWrite(ctlA[8]), .ifIdWrite(ctlA[7]), .idExeWrite(ctlA[6]), .exeMemWrite(ctlA[5]),
    .memWbWrite(ctlA[4]), .ifIdFlush(ctlA[3]), .idExeFlush(ctlA[2]), .exeMemFlush(ctlA[1]),
    .memWbFlush(ctlA[0]), .stallCount(scA), .memTimeout(tmoA), .ctrlState(stA));

  pipeline_hazard_ctrl #(.RESET_FLUSH_CYCLES(RFC), .MEM_TIMEOUT(65535), .WAIT_CNT_W(16)) dutB (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exeRt(exeRt), .exeMemRead(exeMemRead), .branchTaken(branchTaken), .memBusy(memBusy),
    .pcWrite(ctlB[8]), .ifIdWrite(ctlB[7]), .idExeWrite(ctlB[6]), .exeMemWrite(ctlB[5]),
    .memWbWrite(ctlB[4]), .ifIdFlush(ctlB[3]), .idExeFlush(ctlB[2]), .exeMemFlush(ctlB[1]),
    .memWbFlush(ctlB[0]), .stallCount(scB), .memTimeout(tmoB), .ctrlState(stB));

  function automatic in_t mk(int rs, int rt, int ut, int ert, int mr, int br, int mb);
    in_t x;
    x.idRs = 5'(rs); x.idRt = 5'(rt); x.idUsesRt = 1'(ut); x.exeRt = 5'(ert);
    x.exeMemRead = 1'(mr); x.branchTaken = 1'(br); x.memBusy = 1'(mb);
    return x;
  endfunction

  task automatic drive(input in_t x);
    idRs = x.idRs; idRt = x.idRt; idUsesRt = x.idUsesRt; exeRt = x.exeRt;
    exeMemRead = x.exeMemRead; branchTaken = x.branchTaken; memBusy = x.memBusy;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: control vector from the priority rules of the current mode.
  function automatic logic [8:0] mdl_ctl(input mdl_t m, input in_t x);
    bit dep;
    dep = x.exeMemRead && x.exeRt != 0 &&
          (x.exeRt == x.idRs || (x.idUsesRt && x.exeRt == x.idRt));
    if (m.mode == 0) return INITV;
    if (m.mode == 3) return FRZ;
    if (x.memBusy) return FRZ;
    if (x.branchTaken) return BR;
    if (dep) return LU;
    return NORM;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input in_t x, input int limit);
    mdl_t n;
    logic [8:0] c;
    n = m;
    c = mdl_ctl(m, x);
    if (m.mode == 0) begin
      n.initCnt = m.initCnt + 1;
      if (n.initCnt == RFC) n.mode = 1;
    end else if (m.mode != 3) begin
      if (!c[8]) n.stalls = (m.stalls >= 65535) ? 65535 : m.stalls + 1;
      if (x.memBusy) begin
        if (m.busyRun == limit) begin
          n.mode = 3;
          n.tmo  = 1'b1;
        end else begin
          n.busyRun = m.busyRun + 1;
          n.mode    = 2;
        end
      end else begin
        n.busyRun = 0;
        n.mode    = 1;
      end
    end
    return n;
  endfunction

  task automatic chk_mdl(input string tag, input mdl_t m, input in_t x,
                         input logic [8:0] ctl, input logic [1:0] st,
                         input logic [15:0] sc, input logic tmo);
    chk({tag, ".ctl"}, 32'(ctl), 32'(mdl_ctl(m, x)));
    chk({tag, ".state"}, 32'(st), 32'(m.mode));
    chk({tag, ".stallCount"}, 32'(sc), 32'(m.stalls));
    chk({tag, ".memTimeout"}, 32'(tmo), 32'(m.tmo));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[24];
    in_t  idle, busy, lu5, brb;
    mdl_t mA, mB;
    int   burst;

    idle = mk(0, 0, 0, 0, 0, 0, 0);
    busy = mk(0, 0, 0, 0, 0, 0, 1);
    lu5  = mk(5, 0, 0, 5, 1, 0, 0);
    brb  = mk(0, 0, 0, 0, 0, 1, 1);
    tbl[0]  = '{mk(1, 2, 1, 1, 1, 1, 1), INITV, 2'd0, 16'd0, 1'b0};
    tbl[1]  = '{lu5, INITV, 2'd0, 16'd0, 1'b0};
    tbl[2]  = '{idle, INITV, 2'd0, 16'd0, 1'b0};
    tbl[3]  = '{idle, INITV, 2'd0, 16'd0, 1'b0};
    tbl[4]  = '{idle, NORM, 2'd1, 16'd0, 1'b0};
    tbl[5]  = '{lu5, LU, 2'd1, 16'd0, 1'b0};
    tbl[6]  = '{idle, NORM, 2'd1, 16'd1, 1'b0};
    tbl[7]  = '{mk(0, 0, 0, 0, 1, 0, 0), NORM, 2'd1, 16'd1, 1'b0};
    tbl[8]  = '{mk(3, 5, 0, 5, 1, 0, 0), NORM, 2'd1, 16'd1, 1'b0};
    tbl[9]  = '{mk(3, 5, 1, 5, 1, 0, 0), LU, 2'd1, 16'd1, 1'b0};
    tbl[10] = '{idle, NORM, 2'd1, 16'd2, 1'b0};
    tbl[11] = '{mk(5, 0, 0, 5, 1, 1, 0), BR, 2'd1, 16'd2, 1'b0};
    tbl[12] = '{brb, FRZ, 2'd1, 16'd2, 1'b0};
    tbl[13] = '{brb, FRZ, 2'd2, 16'd3, 1'b0};
    tbl[14] = '{brb, FRZ, 2'd2, 16'd4, 1'b0};
    tbl[15] = '{mk(0, 0, 0, 0, 0, 1, 0), BR, 2'd2, 16'd5, 1'b0};
    tbl[16] = '{idle, NORM, 2'd1, 16'd5, 1'b0};
    tbl[17] = '{busy, FRZ, 2'd1, 16'd5, 1'b0};
    tbl[18] = '{busy, FRZ, 2'd2, 16'd6, 1'b0};
    tbl[19] = '{busy, FRZ, 2'd2, 16'd7, 1'b0};
    tbl[20] = '{busy, FRZ, 2'd2, 16'd8, 1'b0};
    tbl[21] = '{busy, FRZ, 2'd2, 16'd9, 1'b0};
    tbl[22] = '{idle, FRZ, 2'd3, 16'd10, 1'b1};
    tbl[23] = '{mk(5, 0, 0, 5, 1, 1, 0), FRZ, 2'd3, 16'd10, 1'b1};

    reset = 1'b0;
    drive(idle);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ctl", 32'(ctlA), 32'(INITV));
    chk("rst.state", 32'(stA), 32'd0);
    chk("rst.stallCount", 32'(scA), 32'd0);
    chk("rst.memTimeout", 32'(tmoA), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].x);
      #1;
      chk($sformatf("tbl%0d.ctl", i), 32'(ctlA), 32'(tbl[i].ctl));
      chk($sformatf("tbl%0d.state", i), 32'(stA), 32'(tbl[i].st));
      chk($sformatf("tbl%0d.stallCount", i), 32'(scA), 32'(tbl[i].sc));
      chk($sformatf("tbl%0d.memTimeout", i), 32'(tmoA), 32'(tbl[i].tmo));
      @(negedge clk);
    end

    // Asynchronous reset out of HALT.
    drive(idle);
    reset = 1'b0;
    #1;
    chk("haltrst.ctl", 32'(ctlA), 32'(INITV));
    chk("haltrst.state", 32'(stA), 32'd0);
    chk("haltrst.stallCount", 32'(scA), 32'd0);
    chk("haltrst.memTimeout", 32'(tmoA), 32'd0);

    // Random traffic on both instances, with occasional reset pulses.
    @(negedge clk);
    reset = 1'b1;
    mA = '{default: 0};
    mB = '{default: 0};
    burst = 0;
    for (int c = 0; c < 2000; c++) begin
      in_t x;
      x = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 5) == 0), 0);
      if (burst > 0) begin
        x.memBusy = 1'b1;
        burst--;
      end else if ($urandom_range(0, 9) == 0) begin
        burst = $urandom_range(1, 6);
        x.memBusy = 1'b1;
      end
      drive(x);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b0;
        mA = '{default: 0};
        mB = '{default: 0};
        #1;
        chk_mdl("rndA", mA, x, ctlA, stA, scA, tmoA);
        chk_mdl("rndB", mB, x, ctlB, stB, scB, tmoB);
        @(negedge clk);
        reset = 1'b1;
      end else begin
        #1;
        chk_mdl("rndA", mA, x, ctlA, stA, scA, tmoA);
        chk_mdl("rndB", mB, x, ctlB, stB, scB, tmoB);
        mA = mdl_next(mA, x, 4);
        mB = mdl_next(mB, x, 65535);
        @(negedge clk);
      end
    end

    // Reset pulsed in the middle of a memory wait.
    drive(idle);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (RFC) @(negedge clk);
    drive(busy);
    repeat (3) @(negedge clk);
    #1;
    chk("midwait.state", 32'(stB), 32'd2);
    chk("midwait.stallCount", 32'(scB), 32'd3);
    reset = 1'b0;
    #1;
    chk("midwaitrst.state", 32'(stB), 32'd0);
    chk("midwaitrst.stallCount", 32'(scB), 32'd0);
    chk("midwaitrst.ctl", 32'(ctlB), 32'(INITV));

    // Long freezes drive the stall counter into saturation without a timeout.
    @(negedge clk);
    drive(idle);
    reset = 1'b1;
    repeat (RFC) @(negedge clk);
    drive(busy);
    repeat (65000) @(negedge clk);
    #1;
    chk("long.stallCount", 32'(scB), 32'd65000);
    chk("long.state", 32'(stB), 32'd2);
    drive(idle);
    @(negedge clk);
    #1;
    chk("gap.state", 32'(stB), 32'd1);
    drive(busy);
    repeat (600) @(negedge clk);
    #1;
    chk("sat.stallCount", 32'(scB), 32'hFFFF);
    chk("sat.state", 32'(stB), 32'd2);
    chk("sat.memTimeout", 32'(tmoB), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline. Drives the write and flush controls of the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.
- Resolves three conditions: load-use hazards (stall plus bubble), taken branches (flush younger stages) and multi-cycle data-memory waits (whole-pipeline freeze with timeout).
- Also performs the post-reset pipeline clear sequence and keeps a stall-cycle performance counter.

Parameters:
- RESET_FLUSH_CYCLES, 4: cycles spent in INIT clearing all pipeline registers after reset release.
- MEM_TIMEOUT, 255: maximum consecutive memBusy cycles tolerated before HALT (1..65535).
- WAIT_CNT_W, 16: width of the memory-wait counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- idRs  in  5  rs field of the instruction in ID (IF/ID output).
- idRt  in  5  rt field of the instruction in ID.
- idUsesRt  in  1  ID instruction reads rt as a source.
- exeRt  in  5  rt of the instruction in EXE (ID/EXE output).
- exeMemRead  in  1  EXE instruction is a load.
- branchTaken  in  1  branch resolved taken, from EXE/MEM output.
- memBusy  in  1  data memory has not completed the current access.
- pcWrite  out  1  PC load enable.
- ifIdWrite, idExeWrite, exeMemWrite, memWbWrite  out  1 each  stage register write enables.
- ifIdFlush, idExeFlush, exeMemFlush, memWbFlush  out  1 each  load zeros on the next edge. Only meaningful when the matching write is 1.
- stallCount  out  16  saturating count of stalled cycles.
- memTimeout  out  1  sticky flag, set on memory timeout.
- ctrlState  out  2  INIT=0, RUN=1, MEM_WAIT=2, HALT=3.

Behaviour:
- Reset (reset=0, asynchronous):
  - ctrlState=INIT; initCnt, waitCnt, stallCount=0; memTimeout=0.
  - Outputs immediately take INIT values.
- Output timing:
  - Write/flush outputs are Mealy: combinational from ctrlState and current inputs.
  - ctrlState, stallCount and memTimeout are registered.
- INIT:
  - pcWrite=0; all four stage writes=1; all four flushes=1.
  - initCnt increments every cycle. When initCnt==RESET_FLUSH_CYCLES-1, next state is RUN.
  - All hazard inputs are ignored in INIT.
- RUN and MEM_WAIT, priority rules (highest first):
  - P1, memBusy=1: pcWrite=0, all writes=0, all flushes=0 (full freeze). Next state MEM_WAIT.
  - P2, branchTaken=1: pcWrite=1; all writes=1; ifIdFlush=idExeFlush=exeMemFlush=1; memWbFlush=0. Next state RUN.
  - P3, load-use: condition is exeMemRead && exeRt!=0 && (exeRt==idRs || (idUsesRt && exeRt==idRt)).
    - Action: pcWrite=0, ifIdWrite=0, idExeWrite=1 with idExeFlush=1 (bubble), exeMemWrite=memWbWrite=1, other flushes 0.
    - Next state RUN. Exactly one stall cycle per hazard, because the bubble clears exeMemRead.
  - P4, otherwise: all writes=1, all flushes=0. Next state RUN.
  - Branch and load-use in the same cycle: branch wins, no stall.
  - A branch arriving during a freeze is held stable by the frozen EXE/MEM register and is applied on the first cycle with memBusy=0.
- waitCnt:
  - Cleared whenever memBusy=0 or state is not RUN/MEM_WAIT.
  - Otherwise increments on each memBusy=1 cycle. It is 1 at the first MEM_WAIT cycle.
  - If memBusy=1 while waitCnt==MEM_TIMEOUT: next state HALT and memTimeout<=1.
- MEM_WAIT exit: the first cycle with memBusy=0 uses the P2–P4 rules; next state RUN.
- HALT:
  - All writes=0, all flushes=0, pcWrite=0.
  - Left only by reset. memTimeout stays 1. stallCount is frozen.
- stallCount:
  - +1 on every RUN/MEM_WAIT cycle with pcWrite=0.
  - Saturates at 16'hFFFF (no wrap).
  - Not incremented in INIT or HALT.
- Reset asserted mid-freeze or in HALT: immediate return to INIT and all counters cleared.

Test Plan:
- Reset, then release; RESET_FLUSH_CYCLES=4 -> 4 cycles of ctrlState=0, pcWrite=0, all flushes=1; ctrlState=1 on cycle 5; stallCount=0.
- RUN, exeMemRead=1, exeRt=5, idRs=5 -> one cycle with pcWrite=0, ifIdWrite=0, idExeFlush=1, stallCount=1. Repeat with exeRt=0 -> no stall. Repeat with idRt=5, idUsesRt=0 -> no stall.
- branchTaken=1 together with the load-use hazard -> pcWrite=1; ifIdFlush=idExeFlush=exeMemFlush=1; memWbFlush=0; stallCount unchanged.
- memBusy=1 for 3 cycles with branchTaken=1 held -> 3 cycles all writes=0, ctrlState=2, stallCount+=3; the 4th cycle applies the branch flush and ctrlState returns to 1.
- MEM_TIMEOUT=4, memBusy held high -> ctrlState=3 after 5 busy cycles, memTimeout=1. Dropping memBusy afterwards keeps HALT; reset low returns to INIT with memTimeout=0.
- stallCount preloaded near saturation by long memBusy runs (MEM_TIMEOUT=65535, stalls separated by memBusy=0 cycles) -> stays at 16'hFFFF. Reset pulsed mid-MEM_WAIT -> immediate INIT, stallCount=0.
